// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the ALU operation scheduler: op codes, ALU select
// one-hots and FSM states.
package alu_ctrl_pkg;

  typedef enum logic [2:0] {
    OP_AND = 3'd0,
    OP_OR  = 3'd1,
    OP_XOR = 3'd2,
    OP_NOT = 3'd3,
    OP_ADD = 3'd4,
    OP_SUB = 3'd5,
    OP_MUL = 3'd6,
    OP_CLR = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_WAIT  = 2'b10,
    ST_RESP  = 2'b11
  } state_e;

  localparam logic [2:0] IN_SEL_PERSIST = 3'b100;
  localparam logic [2:0] IN_SEL_LOAD    = 3'b010;
  localparam logic [2:0] IN_SEL_RESET   = 3'b001;

  localparam logic [6:0] OUT_SEL_AND = 7'b000_0001;
  localparam logic [6:0] OUT_SEL_OR  = 7'b000_0010;
  localparam logic [6:0] OUT_SEL_XOR = 7'b000_0100;
  localparam logic [6:0] OUT_SEL_NOT = 7'b000_1000;
  localparam logic [6:0] OUT_SEL_ADD = 7'b001_0000;
  localparam logic [6:0] OUT_SEL_SUB = 7'b010_0000;
  localparam logic [6:0] OUT_SEL_MUL = 7'b100_0000;

  // CLR has no datapath operation, so it maps to an all-zero select.
  function automatic logic [6:0] out_sel_of(input op_e op);
    case (op)
      OP_AND:  return OUT_SEL_AND;
      OP_OR:   return OUT_SEL_OR;
      OP_XOR:  return OUT_SEL_XOR;
      OP_NOT:  return OUT_SEL_NOT;
      OP_ADD:  return OUT_SEL_ADD;
      OP_SUB:  return OUT_SEL_SUB;
      OP_MUL:  return OUT_SEL_MUL;
      default: return 7'b000_0000;
    endcase
  endfunction

endpackage

// File: rtl/alu_op_scheduler_if.sv
// Request, ALU-control and response bundle between the scheduler (slave)
// and its requesters / ALU datapath / response consumer (master).
interface alu_op_scheduler_if #(
  parameter int WIDTH = 8
);
  logic             req0_valid;
  logic             req0_ready;
  logic [2:0]       req0_op;
  logic             req0_src;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;

  logic             req1_valid;
  logic             req1_ready;
  logic [2:0]       req1_op;
  logic             req1_src;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;

  logic [2:0]       alu_in_sel;
  logic [6:0]       alu_out_sel;
  logic [WIDTH-1:0] alu_num1;
  logic [WIDTH-1:0] alu_num2;
  logic [WIDTH-1:0] alu_result;

  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [WIDTH-1:0] rsp_data;

  modport slave (
    input  req0_valid, req0_op, req0_src, req0_a, req0_b,
    output req0_ready,
    input  req1_valid, req1_op, req1_src, req1_a, req1_b,
    output req1_ready,
    output alu_in_sel, alu_out_sel, alu_num1, alu_num2,
    input  alu_result,
    output rsp_valid, rsp_id, rsp_data,
    input  rsp_ready
  );

  modport master (
    output req0_valid, req0_op, req0_src, req0_a, req0_b,
    input  req0_ready,
    output req1_valid, req1_op, req1_src, req1_a, req1_b,
    input  req1_ready,
    input  alu_in_sel, alu_out_sel, alu_num1, alu_num2,
    output alu_result,
    input  rsp_valid, rsp_id, rsp_data,
    output rsp_ready
  );
endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant; the pointer moves to the requester that was not
// served whenever an advance pulse arrives.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_i,
  input  logic       advance_i,
  input  logic       served_i,
  output logic [1:0] gnt_o
);

  logic ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (advance_i) ptr_d = ~served_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= 1'b0;
    else        ptr_q <= ptr_d;
  end

  always_comb begin
    gnt_o = 2'b00;
    case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = ptr_q ? 2'b10 : 2'b01;
      default: gnt_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/alu_op_scheduler.sv
// Arbitrates two requesters onto the shared ALU, sequences its controls over
// the ALU latency and returns the result; keeps the last result for chaining.
module alu_op_scheduler
  import alu_ctrl_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int ALU_LAT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             on,
  alu_op_scheduler_if.slave bus,
  output logic [WIDTH-1:0] acc,
  output logic [1:0]       state
);

  localparam int CNT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  op_e              op_q, op_d;
  logic             src_q, src_d;
  logic             id_q, id_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;

  logic [1:0] gnt;
  logic       advance;
  logic       take0, take1;

  assign advance = (state_q == ST_RESP) && bus.rsp_ready;

  rr_arbiter2 u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_i     ({bus.req1_valid, bus.req0_valid}),
    .advance_i (advance),
    .served_i  (id_q),
    .gnt_o     (gnt)
  );

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    op_d            = op_q;
    src_d           = src_q;
    id_d            = id_q;
    a_d             = a_q;
    b_d             = b_q;
    acc_d           = acc_q;
    rsp_data_d      = rsp_data_q;
    bus.req0_ready  = 1'b0;
    bus.req1_ready  = 1'b0;
    bus.alu_in_sel  = 3'b000;
    bus.alu_out_sel = 7'b000_0000;
    bus.alu_num1    = '0;
    bus.alu_num2    = '0;
    bus.rsp_valid   = 1'b0;
    take0           = 1'b0;
    take1           = 1'b0;

    // The ALU sees the latched operation for the whole ISSUE+WAIT window.
    if (state_q == ST_ISSUE || state_q == ST_WAIT) begin
      bus.alu_in_sel  = src_q ? IN_SEL_PERSIST : IN_SEL_LOAD;
      bus.alu_out_sel = out_sel_of(op_q);
      bus.alu_num1    = src_q ? acc_q : a_q;
      bus.alu_num2    = b_q;
    end

    case (state_q)
      ST_IDLE: begin
        bus.req0_ready = rst_n & on & gnt[0];
        bus.req1_ready = rst_n & on & gnt[1];
        take0 = bus.req0_valid & bus.req0_ready;
        take1 = bus.req1_valid & bus.req1_ready;
        if (take0) begin
          op_d    = op_e'(bus.req0_op);
          src_d   = bus.req0_src;
          a_d     = bus.req0_a;
          b_d     = bus.req0_b;
          id_d    = 1'b0;
          state_d = ST_ISSUE;
        end else if (take1) begin
          op_d    = op_e'(bus.req1_op);
          src_d   = bus.req1_src;
          a_d     = bus.req1_a;
          b_d     = bus.req1_b;
          id_d    = 1'b1;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (op_q == OP_CLR) begin
          bus.alu_in_sel  = IN_SEL_RESET;
          bus.alu_out_sel = 7'b000_0000;
          acc_d           = '0;
          rsp_data_d      = '0;
          state_d         = ST_RESP;
        end else begin
          cnt_d   = CNT_W'(ALU_LAT - 1);
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          rsp_data_d = bus.alu_result;
          acc_d      = bus.alu_result;
          state_d    = ST_RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_RESP: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      op_q       <= OP_AND;
      src_q      <= 1'b0;
      id_q       <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      acc_q      <= '0;
      rsp_data_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      src_q      <= src_d;
      id_q       <= id_d;
      a_q        <= a_d;
      b_q        <= b_d;
      acc_q      <= acc_d;
      rsp_data_q <= rsp_data_d;
    end
  end

  assign bus.rsp_id   = id_q;
  assign bus.rsp_data = rsp_data_q;
  assign acc          = acc_q;
  assign state        = state_q;

endmodule

// File: tb/tb_alu_op_scheduler.sv
// Directed and randomized bench for alu_op_scheduler against an
// operation-level reference model with a one-cycle ALU stand-in.
module tb_alu_op_scheduler;
  import alu_ctrl_pkg::*;

  localparam int WIDTH   = 8;
  localparam int ALU_LAT = 1;

  typedef struct {
    logic [2:0]       op;
    logic             src;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } req_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             on = 1'b0;
  logic [WIDTH-1:0] acc;
  logic [1:0]       state;

  int               passCount = 0;
  int               checkCount = 0;
  logic [WIDTH-1:0] mAcc = '0;
  logic             mRr = 1'b0;

  alu_op_scheduler_if #(.WIDTH(WIDTH)) bus ();

  alu_op_scheduler #(.WIDTH(WIDTH), .ALU_LAT(ALU_LAT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .on    (on),
    .bus   (bus),
    .acc   (acc),
    .state (state)
  );

  always #5 clk = ~clk;

  // Datapath stand-in: result appears one clock after the controls.
  always @(posedge clk) begin
    case (bus.alu_out_sel)
      7'b000_0001: bus.alu_result <= bus.alu_num1 & bus.alu_num2;
      7'b000_0010: bus.alu_result <= bus.alu_num1 | bus.alu_num2;
      7'b000_0100: bus.alu_result <= bus.alu_num1 ^ bus.alu_num2;
      7'b000_1000: bus.alu_result <= ~bus.alu_num1;
      7'b001_0000: bus.alu_result <= bus.alu_num1 + bus.alu_num2;
      7'b010_0000: bus.alu_result <= bus.alu_num1 - bus.alu_num2;
      7'b100_0000: bus.alu_result <= bus.alu_num1 * bus.alu_num2;
      default:     bus.alu_result <= '0;
    endcase
  end

  function automatic logic [WIDTH-1:0] aluRef(input logic [2:0] op, input logic [WIDTH-1:0] x,
                                              input logic [WIDTH-1:0] y);
    case (op)
      3'd0:    return x & y;
      3'd1:    return x | y;
      3'd2:    return x ^ y;
      3'd3:    return ~x;
      3'd4:    return WIDTH'((int'(x) + int'(y)) % 256);
      3'd5:    return WIDTH'((int'(x) - int'(y) + 256) % 256);
      3'd6:    return WIDTH'((int'(x) * int'(y)) % 256);
      default: return '0;
    endcase
  endfunction

  function automatic req_t mk(input logic [2:0] op, input logic src, input logic [WIDTH-1:0] a,
                              input logic [WIDTH-1:0] b);
    req_t r;
    r.op  = op;
    r.src = src;
    r.a   = a;
    r.b   = b;
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // One full transaction; entered and left on a falling edge.
  task automatic applyStimulus(input logic v0, input logic v1, input req_t r0, input req_t r1,
                               input bit keepValid, input int hold, input bit dropOn,
                               input string name);
    logic             g;
    req_t             r;
    bit               clr;
    logic [WIDTH-1:0] expN1, expRes;
    logic [2:0]       expIn;
    logic [6:0]       expOut;
    int               lat;

    g      = (v0 && v1) ? mRr : v1;
    r      = g ? r1 : r0;
    clr    = (r.op == 3'd7);
    expN1  = r.src ? mAcc : r.a;
    expRes = clr ? '0 : aluRef(r.op, expN1, r.b);
    expIn  = clr ? 3'b001 : (r.src ? 3'b100 : 3'b010);
    expOut = clr ? 7'd0 : 7'(1 << r.op);

    bus.req0_valid = v0; bus.req0_op = r0.op; bus.req0_src = r0.src;
    bus.req0_a = r0.a;   bus.req0_b = r0.b;
    bus.req1_valid = v1; bus.req1_op = r1.op; bus.req1_src = r1.src;
    bus.req1_a = r1.a;   bus.req1_b = r1.b;
    #1;
    checkOutput({name, "_ready0"}, 32'(bus.req0_ready), 32'(!g));
    checkOutput({name, "_ready1"}, 32'(bus.req1_ready), 32'(g));

    @(negedge clk);
    if (!keepValid) begin
      bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
      bus.req0_a = 8'($urandom); bus.req0_b = 8'($urandom); bus.req0_op = 3'($urandom);
      bus.req1_a = 8'($urandom); bus.req1_b = 8'($urandom); bus.req1_op = 3'($urandom);
    end
    #1;
    checkOutput({name, "_issue_state"}, 32'(state), 32'(2'b01));
    checkOutput({name, "_issue_in_sel"}, 32'(bus.alu_in_sel), 32'(expIn));
    checkOutput({name, "_issue_out_sel"}, 32'(bus.alu_out_sel), 32'(expOut));
    checkOutput({name, "_issue_ready"}, 32'({bus.req1_ready, bus.req0_ready}), 32'(0));
    if (!clr) begin
      checkOutput({name, "_issue_num1"}, 32'(bus.alu_num1), 32'(expN1));
      checkOutput({name, "_issue_num2"}, 32'(bus.alu_num2), 32'(r.b));
    end
    if (dropOn) on = 1'b0;

    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (!bus.rsp_valid) begin
        checkOutput({name, "_wait_in_sel"}, 32'(bus.alu_in_sel), 32'(expIn));
        checkOutput({name, "_wait_out_sel"}, 32'(bus.alu_out_sel), 32'(expOut));
        checkOutput({name, "_wait_num1"}, 32'(bus.alu_num1), 32'(expN1));
      end
    end while (!bus.rsp_valid && lat < 8);

    checkOutput({name, "_latency"}, 32'(lat), clr ? 32'(1) : 32'(ALU_LAT + 1));
    checkOutput({name, "_rsp_valid"}, 32'(bus.rsp_valid), 32'(1));
    checkOutput({name, "_rsp_id"}, 32'(bus.rsp_id), 32'(g));
    checkOutput({name, "_rsp_data"}, 32'(bus.rsp_data), 32'(expRes));
    checkOutput({name, "_acc"}, 32'(acc), 32'(expRes));
    checkOutput({name, "_resp_state"}, 32'(state), 32'(2'b11));
    checkOutput({name, "_resp_in_sel"}, 32'(bus.alu_in_sel), 32'(0));

    repeat (hold) begin
      @(negedge clk);
      checkOutput({name, "_hold_valid"}, 32'(bus.rsp_valid), 32'(1));
      checkOutput({name, "_hold_data"}, 32'(bus.rsp_data), 32'(expRes));
      checkOutput({name, "_hold_ready"}, 32'({bus.req1_ready, bus.req0_ready}), 32'(0));
    end

    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    mAcc = expRes;
    mRr  = ~g;
    checkOutput({name, "_back_idle"}, 32'(state), 32'(2'b00));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired observed=running required=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    req_t ra, rb;
    bus.req0_valid = 1'b0; bus.req0_op = '0; bus.req0_src = 1'b0; bus.req0_a = '0; bus.req0_b = '0;
    bus.req1_valid = 1'b0; bus.req1_op = '0; bus.req1_src = 1'b0; bus.req1_a = '0; bus.req1_b = '0;
    bus.rsp_ready  = 1'b0;

    // Held in reset with a request pending: nothing may be granted.
    repeat (2) @(negedge clk);
    on = 1'b1;
    bus.req0_valid = 1'b1;
    #1;
    checkOutput("rst_state", 32'(state), 32'(0));
    checkOutput("rst_acc", 32'(acc), 32'(0));
    checkOutput("rst_rsp_valid", 32'(bus.rsp_valid), 32'(0));
    checkOutput("rst_in_sel", 32'(bus.alu_in_sel), 32'(0));
    checkOutput("rst_out_sel", 32'(bus.alu_out_sel), 32'(0));
    checkOutput("rst_ready0", 32'(bus.req0_ready), 32'(0));
    bus.req0_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    applyStimulus(1, 0, mk(3'd6, 1'b0, 8'd3, 8'd2), mk(3'd0, 1'b0, 8'd0, 8'd0), 0, 0, 0, "mul_load");
    applyStimulus(0, 1, mk(3'd0, 1'b0, 8'd0, 8'd0), mk(3'd4, 1'b1, 8'd99, 8'd4), 0, 0, 0, "add_persist");
    applyStimulus(1, 0, mk(3'd6, 1'b0, 8'd87, 8'd26), mk(3'd0, 1'b0, 8'd0, 8'd0), 0, 0, 0, "mul_ovf");
    applyStimulus(0, 1, mk(3'd0, 1'b0, 8'd0, 8'd0), mk(3'd7, 1'b0, 8'd5, 8'd5), 0, 0, 0, "clr");

    // Both requesters held valid: service must alternate starting at 0.
    ra = mk(3'd2, 1'b0, 8'h5a, 8'h0f);
    rb = mk(3'd5, 1'b1, 8'd20, 8'd7);
    repeat (4) applyStimulus(1, 1, ra, rb, 1, 0, 0, "arb");
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;

    applyStimulus(1, 1, mk(3'd1, 1'b0, 8'h30, 8'h03), mk(3'd3, 1'b1, 8'h00, 8'hff), 1, 5, 0, "backpressure");
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;

    on = 1'b0;
    bus.req0_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checkOutput("off_ready0", 32'(bus.req0_ready), 32'(0));
      checkOutput("off_state", 32'(state), 32'(0));
    end
    bus.req0_valid = 1'b0;
    on = 1'b1;

    applyStimulus(1, 0, mk(3'd3, 1'b0, 8'ha5, 8'h11), mk(3'd0, 1'b0, 8'd0, 8'd0), 0, 0, 1, "on_drop");
    bus.req1_valid = 1'b1;
    repeat (2) begin
      @(negedge clk);
      checkOutput("on_drop_no_grant", 32'({bus.req1_ready, bus.req0_ready}), 32'(0));
      checkOutput("on_drop_idle", 32'(state), 32'(0));
    end
    bus.req1_valid = 1'b0;
    on = 1'b1;

    for (int i = 0; i < 24; i++) begin
      int v;
      v  = $urandom_range(1, 3);
      ra = mk(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
      rb = mk(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
      applyStimulus(1'(v & 1), 1'(v >> 1), ra, rb, 0, $urandom_range(0, 2), 0, "rand");
    end

    applyStimulus(1, 0, mk(3'd4, 1'b0, 8'd9, 8'd1), mk(3'd0, 1'b0, 8'd0, 8'd0), 0, 0, 0, "pre_reset");

    // Reset while the ALU is busy: everything clears at once, no response.
    bus.req0_valid = 1'b1; bus.req0_op = 3'd6; bus.req0_src = 1'b0;
    bus.req0_a = 8'd5; bus.req0_b = 8'd5;
    @(negedge clk);
    bus.req0_valid = 1'b0;
    @(negedge clk);
    checkOutput("mid_op_state", 32'(state), 32'(2'b10));
    #1 rst_n = 1'b0;
    #1;
    checkOutput("async_rst_state", 32'(state), 32'(0));
    checkOutput("async_rst_acc", 32'(acc), 32'(0));
    checkOutput("async_rst_rsp_valid", 32'(bus.rsp_valid), 32'(0));
    checkOutput("async_rst_in_sel", 32'(bus.alu_in_sel), 32'(0));
    checkOutput("async_rst_out_sel", 32'(bus.alu_out_sel), 32'(0));
    mAcc = '0;
    mRr  = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      checkOutput("post_rst_no_rsp", 32'(bus.rsp_valid), 32'(0));
    end

    applyStimulus(1, 1, mk(3'd4, 1'b1, 8'd0, 8'd7), mk(3'd0, 1'b0, 8'd1, 8'd1), 0, 0, 0, "post_rst_arb");

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
